// File: rtl/axis_receiver_pkg.sv
// Shared widths, node constants and RX ingress FSM encoding for the axis_receiver slice.
package axis_receiver_pkg;

    localparam int DATAW          = 16;
    localparam int FIFO_DEPTH     = 8;
    localparam int AXIS_DESTW     = 2;
    localparam int AXIS_USERW     = 2;
    localparam int AXIS_IDW       = 2;
    localparam int AXIS_STRBW     = 4;
    localparam int AXIS_KEEPW     = 4;
    localparam int AXIS_MAX_DATAW = 32;

    localparam logic [AXIS_DESTW-1:0] NODE_ADDR_DEFAULT    = 2'b00;
    localparam logic [AXIS_USERW-1:0] EXPECTED_SRC_DEFAULT = 2'b11;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_rx_fifo.sv
// Show-ahead FIFO: head entry is always presented on data_out; full/empty are registered.
module axis_rx_fifo #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
            full_r  <= (count_s == CNT_DEPTH);
            empty_r <= (count_s == CNT_ZERO);
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    assign data_out = empty_r ? '0 : mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/axis_receiver.sv
// NoC AXI-Stream receive endpoint: address filter, show-ahead buffer, packet/drop statistics.
// Optional source filter enabled by defining SRC_FILTER_EN.
module axis_receiver
    import axis_receiver_pkg::*;
#(
    parameter int                     DATA_WIDTH   = DATAW,
    parameter int                     DEPTH        = FIFO_DEPTH,
    parameter logic [AXIS_DESTW-1:0]  NODE_ADDR    = NODE_ADDR_DEFAULT,
    parameter logic [AXIS_USERW-1:0]  EXPECTED_SRC = EXPECTED_SRC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axis_receiver_interface_tvalid,
    output logic                      axis_receiver_interface_tready,
    input  logic                      axis_receiver_interface_tlast,
    input  logic [AXIS_DESTW-1:0]     axis_receiver_interface_tdest,
    input  logic [AXIS_USERW-1:0]     axis_receiver_interface_tuser,
    input  logic [AXIS_IDW-1:0]       axis_receiver_interface_tid,
    input  logic [AXIS_STRBW-1:0]     axis_receiver_interface_tstrb,
    input  logic [AXIS_KEEPW-1:0]     axis_receiver_interface_tkeep,
    input  logic [AXIS_MAX_DATAW-1:0] axis_receiver_interface_tdata,
    output logic [DATA_WIDTH-1:0]     rx_tdata,
    output logic                      rx_tlast,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      in_packet,
    output logic [15:0]               packet_count,
    output logic [15:0]               drop_count
);

    logic [DATA_WIDTH:0] fifo_out_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                accept_s;
    logic                match_s;
    logic                store_s;
    logic                drop_s;
    logic                pop_s;
    rx_state_t           state_r;
    logic [15:0]         packet_count_r;
    logic [15:0]         drop_count_r;
    logic                unused_s;

    assign unused_s = ^{axis_receiver_interface_tid,
                        axis_receiver_interface_tstrb,
                        axis_receiver_interface_tkeep,
                        axis_receiver_interface_tuser,
                        axis_receiver_interface_tdata[AXIS_MAX_DATAW-1:DATA_WIDTH]};

    // Ready is forced low during reset so nothing is accepted while the buffer clears.
    assign axis_receiver_interface_tready = ~fifo_full_s & ~rst;
    assign accept_s = axis_receiver_interface_tvalid & axis_receiver_interface_tready;

`ifdef SRC_FILTER_EN
    assign match_s = (axis_receiver_interface_tdest == NODE_ADDR) &&
                     (axis_receiver_interface_tuser == EXPECTED_SRC);
`else
    assign match_s = (axis_receiver_interface_tdest == NODE_ADDR);
`endif

    assign store_s = accept_s & match_s;
    assign drop_s  = accept_s & ~match_s;
    assign pop_s   = rx_valid & rx_ready;

    axis_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH + 1),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (store_s),
        .data_in  ({axis_receiver_interface_tlast,
                    axis_receiver_interface_tdata[DATA_WIDTH-1:0]}),
        .pop      (pop_s),
        .data_out (fifo_out_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    assign rx_valid = ~fifo_empty_s;
    assign rx_tdata = fifo_out_s[DATA_WIDTH-1:0];
    assign rx_tlast = fifo_out_s[DATA_WIDTH];

    // Ingress FSM follows stored flits only; dropped flits never move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RX_IDLE;
        end else if (store_s) begin
            case (state_r)
                RX_IDLE: state_r <= axis_receiver_interface_tlast ? RX_IDLE : RX_RECV;
                RX_RECV: state_r <= axis_receiver_interface_tlast ? RX_IDLE : RX_RECV;
                default: state_r <= RX_IDLE;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign in_packet = (state_r == RX_RECV);

    // Saturating delivery and drop statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            packet_count_r <= 16'd0;
            drop_count_r   <= 16'd0;
        end else begin
            if (pop_s && rx_tlast) begin
                packet_count_r <= sat_inc16(packet_count_r);
            end
            if (drop_s) begin
                drop_count_r <= sat_inc16(drop_count_r);
            end
        end
    end

    assign packet_count = packet_count_r;
    assign drop_count   = drop_count_r;

endmodule

// File: tb/tb_axis_receiver.sv
// Randomized self-checking bench for axis_receiver against a queue-based reference model.
module tb_axis_receiver;
    import axis_receiver_pkg::*;

    localparam int DW  = DATAW;
    localparam int DEP = FIFO_DEPTH;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      tvalid = 1'b0;
    logic                      tready;
    logic                      tlast = 1'b0;
    logic [AXIS_DESTW-1:0]     tdest = '0;
    logic [AXIS_USERW-1:0]     tuser = 2'b11;
    logic [AXIS_IDW-1:0]       tid = '0;
    logic [AXIS_STRBW-1:0]     tstrb = '1;
    logic [AXIS_KEEPW-1:0]     tkeep = '1;
    logic [AXIS_MAX_DATAW-1:0] tdata = '0;
    logic [DW-1:0]             rx_tdata;
    logic                      rx_tlast;
    logic                      rx_valid;
    logic                      rx_ready = 1'b0;
    logic                      in_packet;
    logic [15:0]               packet_count;
    logic [15:0]               drop_count;

    always #5 clk = ~clk;

    axis_receiver dut (
        .clk                            (clk),
        .rst                            (rst),
        .axis_receiver_interface_tvalid (tvalid),
        .axis_receiver_interface_tready (tready),
        .axis_receiver_interface_tlast  (tlast),
        .axis_receiver_interface_tdest  (tdest),
        .axis_receiver_interface_tuser  (tuser),
        .axis_receiver_interface_tid    (tid),
        .axis_receiver_interface_tstrb  (tstrb),
        .axis_receiver_interface_tkeep  (tkeep),
        .axis_receiver_interface_tdata  (tdata),
        .rx_tdata                       (rx_tdata),
        .rx_tlast                       (rx_tlast),
        .rx_valid                       (rx_valid),
        .rx_ready                       (rx_ready),
        .in_packet                      (in_packet),
        .packet_count                   (packet_count),
        .drop_count                     (drop_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: delivered-order queue of {last, data} plus packet state and counters.
    logic [DW:0] mq[$];
    bit          m_inpkt = 1'b0;
    int          m_pkts  = 0;
    int          m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit flit_wanted(input logic [AXIS_DESTW-1:0] d, input logic [AXIS_USERW-1:0] u);
`ifdef SRC_FILTER_EN
        return (d == 2'b00) && (u == 2'b11);
`else
        return (d == 2'b00) && (u == u);
`endif
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_inpkt = 1'b0;
        m_pkts  = 0;
        m_drops = 0;
    endtask

    task automatic check_outputs();
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, mq.size() != 0});
        chk("tready", {31'd0, tready}, {31'd0, (!rst) && (mq.size() < DEP)});
        if (mq.size() != 0) begin
            chk("rx_tdata", {16'd0, rx_tdata}, {16'd0, mq[0][DW-1:0]});
            chk("rx_tlast", {31'd0, rx_tlast}, {31'd0, mq[0][DW]});
        end
        if (rst) begin
            chk("rst_tdata", {16'd0, rx_tdata}, 32'd0);
            chk("rst_tlast", {31'd0, rx_tlast}, 32'd0);
        end
        chk("in_packet", {31'd0, in_packet}, {31'd0, m_inpkt});
        chk("packet_count", {16'd0, packet_count}, m_pkts);
        chk("drop_count", {16'd0, drop_count}, m_drops);
    endtask

    task automatic model_edge();
        bit          acc;
        bit          pop;
        logic [DW:0] w;
        if (rst) begin
            model_clear();
        end else begin
            acc = tvalid && (mq.size() < DEP);
            pop = (mq.size() != 0) && rx_ready;
            if (pop) begin
                w = mq.pop_front();
                if (w[DW]) m_pkts = sat(m_pkts);
            end
            if (acc) begin
                if (flit_wanted(tdest, tuser)) begin
                    mq.push_back({tlast, tdata[DW-1:0]});
                    m_inpkt = !tlast;
                end else begin
                    m_drops = sat(m_drops);
                end
            end
        end
    endtask

    // One clock: check settled outputs on the falling edge, advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic flit(input bit v, input bit l, input logic [1:0] d, input logic [1:0] u, input logic [31:0] x);
        tvalid = v; tlast = l; tdest = d; tuser = u; tdata = x;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Three-flit packet, consumer always ready.
        rx_ready = 1'b1;
        flit(1'b1, 1'b0, 2'b00, 2'b11, 32'hABCD_0005);
        flit(1'b1, 1'b0, 2'b00, 2'b11, 32'h0000_0006);
        flit(1'b1, 1'b1, 2'b00, 2'b11, 32'h0000_0007);
        tvalid = 1'b0;
        repeat (4) cycle();
        chk("pkt1_delivered", {16'd0, packet_count}, 32'd1);

        // Back-pressure: fill past capacity, then drain.
        rx_ready = 1'b0;
        for (int i = 0; i < DEP + 2; i++) begin
            flit(1'b1, (i == DEP - 1), 2'b00, 2'b11, 32'h100 + i);
        end
        chk("full_tready", {31'd0, tready}, 32'd0);
        tvalid = 1'b0;
        rx_ready = 1'b1;
        repeat (DEP + 3) cycle();

        // Wrong destination, then wrong source.
        flit(1'b1, 1'b1, 2'b01, 2'b11, 32'h0000_0055);
        flit(1'b1, 1'b1, 2'b00, 2'b01, 32'h0000_0066);
        tvalid = 1'b0;
        repeat (3) cycle();

        // Reset in the middle of a stalled packet.
        rx_ready = 1'b0;
        flit(1'b1, 1'b0, 2'b00, 2'b11, 32'h0000_0A01);
        flit(1'b1, 1'b0, 2'b00, 2'b11, 32'h0000_0A02);
        tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("async_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("async_rst_tready", {31'd0, tready}, 32'd0);
        chk("async_rst_inpkt", {31'd0, in_packet}, 32'd0);
        chk("async_rst_pkts", {16'd0, packet_count}, 32'd0);
        chk("async_rst_tdata", {16'd0, rx_tdata}, 32'd0);
        cycle();
        rst = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) flit(1'b1, (i == 3), 2'b00, 2'b11, 32'hB00 + i);
        tvalid = 1'b0;
        repeat (5) cycle();

        // Full buffer draining while single-flit packets arrive.
        rx_ready = 1'b0;
        for (int i = 0; i < DEP; i++) flit(1'b1, 1'b0, 2'b00, 2'b11, 32'hC00 + i);
        rx_ready = 1'b1;
        for (int i = 0; i < 2 * DEP; i++) flit(1'b1, 1'b1, 2'b00, 2'b11, 32'hD00 + i);
        tvalid = 1'b0;
        repeat (2 * DEP + 2) cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tvalid   = ($urandom_range(0, 3) != 0);
            tlast    = ($urandom_range(0, 3) == 0);
            tdest    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tuser    = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            tdata    = $urandom;
            rx_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        tvalid = 1'b0;
        rx_ready = 1'b1;
        repeat (DEP + 2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_receiver.md
# axis_receiver

Receive-side endpoint of the rtl_add NoC AXI-Stream path: accepts flits addressed to this node, buffers them in a show-ahead FIFO and presents them to a local consumer with a valid/ready handshake and per-packet last flag. It is the mirror of the client transmit path. The consumer sees a flat `DATAW`-wide stream plus packet and drop statistics.

## Interface
- DATA_WIDTH, default `DATAW: consumer payload width; low bits of tdata.
- DEPTH, default `FIFO_DEPTH: buffer entries; power of two, ≥2.
- NODE_ADDR, default `AXIS_DESTW'b0: tdest value accepted by this node.
- EXPECTED_SRC, default `AXIS_USERW'b11: permitted tuser, used only with the filter enabled.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- axis_receiver_interface_tvalid  in  1  NoC flit valid.
- axis_receiver_interface_tready  out  1  NoC flit ready.
- axis_receiver_interface_tlast  in  1  last flit of packet.
- axis_receiver_interface_tdest  in  `AXIS_DESTW  destination node.
- axis_receiver_interface_tuser  in  `AXIS_USERW  source node.
- axis_receiver_interface_tid / tstrb / tkeep  in  `AXIS_IDW / `AXIS_STRBW / `AXIS_KEEPW  ignored.
- axis_receiver_interface_tdata  in  `AXIS_MAX_DATAW  flit payload.
- rx_tdata  out  DATA_WIDTH  payload to consumer.
- rx_tlast  out  1  payload ends a packet.
- rx_valid  out  1  rx_tdata/rx_tlast valid.
- rx_ready  in  1  consumer accepts.
- in_packet  out  1  ingress FSM in RECV.
- packet_count  out  16  packets fully delivered to consumer.
- drop_count  out  16  flits accepted but discarded.

## Operation
- Ingress accept: tvalid && tready. Accepted flit is stored iff tdest == NODE_ADDR (and, with filter, tuser == EXPECTED_SRC); otherwise discarded, drop_count +1. Discarded flits never stall the NoC.
- Stored word = {tlast, tdata[DATA_WIDTH-1:0]}; upper tdata bits dropped.
- tready = ~full; held 0 while rst asserted.
- Ingress FSM tracks stored flits only: IDLE → RECV on stored flit with tlast=0; RECV → IDLE on stored flit with tlast=1; single-flit packet (tlast=1 in IDLE) stays IDLE. in_packet = (state == RECV).
- Egress: rx_valid = ~empty; rx_tdata/rx_tlast = head entry; pop on rx_valid && rx_ready.
- packet_count +1 on pop with rx_tlast=1. Both counters saturate at 16'hFFFF.
- Reset (any time, including mid-packet): FIFO emptied, FSM IDLE, counters 0, rx_valid 0, rx_tlast 0, rx_tdata 0, tready 0, in_packet 0. Partial packet discarded without counting.

## Timing
- Stored flit accepted at edge N appears on rx_valid after edge N (one-cycle latency); no combinational tvalid→rx_valid bypass.
- Full: tready 0 even if a pop occurs in the same cycle (no full-bypass); tready returns 1 the cycle after the pop.
- Empty: simultaneous push and pop impossible (rx_valid 0); push visible next cycle.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both complete.
- Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
- Counter updates visible one cycle after the causing handshake.

## Configuration
- SRC_FILTER_EN defined: flits with tuser != EXPECTED_SRC are dropped (counted in drop_count) even if tdest matches.
- Undefined: tuser ignored; only tdest filters.

## Structure
- Shared package/header static_params.vh: `DATAW, `FIFO_DEPTH, all `AXIS_* widths, node address constants; add RX FSM state encodings (IDLE=0, RECV=1).
- One sub-module: axis_rx_fifo, show-ahead FIFO with asynchronous active-high reset, parameters DATA_WIDTH (DATAW+1) and DEPTH, outputs data_out/full/empty.

## Test plan
- Reset, then 3-flit packet tdest=0, tuser=2'b11, data 5,6,7 (tlast on 7), rx_ready=1 → rx_tdata 5,6,7 one cycle after each accept, rx_tlast only on 7, packet_count=1, in_packet 1 between flits 1 and 3.
- rx_ready=0, push DEPTH+2 flits → tready drops after DEPTH stored, no loss; release rx_ready → all DEPTH in order, tready 1 one cycle after first pop.
- Flit with tdest=1 → accepted, not delivered, drop_count=1, FSM unchanged.
- With SRC_FILTER_EN, flit tuser=2'b01 → dropped, drop_count=1; without macro → delivered.
- Assert rst after 2 of 4 flits → outputs to reset values immediately, FIFO empty, packet_count 0; next full packet delivered cleanly.
- Single-flit packet tlast=1 while full FIFO drains concurrently → in_packet stays 0, packet_count increments exactly once per tlast pop.
